// File: rtl/scan_pkg.sv
// Shared definitions for the scan-chain sequencer: controller states,
// default scan word width and default scan-clock divide ratio.
package scan_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_SC_DIV = 2000000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } scan_state_t;

    // One-hot grant vector for a requester index (0 = host, 1 = calibration).
    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sc_sync2.sv
// Two-flop synchronizer for the datapath done flag, plus a third flop
// that provides a one-cycle rising-edge strobe in the clki domain.
module sc_sync2 (
    input  logic clki,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic meta;
    logic sync_q;
    logic sync_d;

    // Shift the asynchronous flag through the synchronizer and edge-detect stage.
    always_ff @(posedge clki) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_in;
            sync_q <= meta;
            sync_d <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~sync_d;

endmodule

// File: rtl/scan_chain_sequencer.sv
// Scan-chain sequencer: round-robin shares the scan datapath between the
// host command path (req[0]) and the calibration loop (req[1]), runs one
// scan per grant and returns the scanned-out word with a one-cycle ack.
// Optional feature macro: SCAN_TIMEOUT_EN adds a SHIFT-state watchdog that
// ends a stuck scan with err=1 and rdata=0.
module scan_chain_sequencer
    import scan_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SC_DIV         = DEF_SC_DIV,
    parameter int ARM_CYCLES     = SC_DIV + 4,
    parameter int TIMEOUT_CYCLES = 64 * SC_DIV
) (
    input  logic              clki,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        grant,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              sc_clk_enb,
    output logic              sc_data_enb,
    output logic [DATA_W-1:0] sc_data_in,
    input  logic [DATA_W-1:0] sc_out,
    input  logic              sc_done
);

    // The data-enable hold must always cover at least one full scan-clock
    // period, so a too-small ARM_CYCLES is stretched to SC_DIV+1.
    localparam int ARM_LIMIT = (ARM_CYCLES > SC_DIV) ? ARM_CYCLES : SC_DIV + 1;
    localparam int ARM_W     = (ARM_LIMIT > 1) ? $clog2(ARM_LIMIT) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_LIMIT - 1);

`ifdef SCAN_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign err = 1'b0;
`endif

    scan_state_t      state;
    logic             rr_last;
    logic             cur_idx;
    logic             win_idx;
    logic [ARM_W-1:0] arm_cnt;
    logic             cap_cnt;
    logic             done_sync;
    logic             done_rise;

    sc_sync2 u_done_sync (
        .clki     (clki),
        .rst_n    (rst_n),
        .async_in (sc_done),
        .sync_out (done_sync),
        .rise     (done_rise)
    );

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        win_idx = 1'b0;
        if (req == 2'b11) begin
            win_idx = ~rr_last;
        end else begin
            win_idx = req[1];
        end
    end

    // Transaction FSM with all datapath controls and responses registered.
    always_ff @(posedge clki) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 2'b00;
            ack         <= 1'b0;
            rdata       <= '0;
            busy        <= 1'b0;
            sc_clk_enb  <= 1'b1;
            sc_data_enb <= 1'b1;
            sc_data_in  <= '0;
            rr_last     <= 1'b1;
            cur_idx     <= 1'b0;
            arm_cnt     <= '0;
            cap_cnt     <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
            err         <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        cur_idx     <= win_idx;
                        grant       <= grant_onehot(win_idx);
                        sc_data_in  <= win_idx ? wdata1 : wdata0;
                        sc_clk_enb  <= 1'b0;
                        sc_data_enb <= 1'b1;
                        busy        <= 1'b1;
                        arm_cnt     <= '0;
                        state       <= ARM;
                    end
                end
                ARM: begin
                    if (arm_cnt == ARM_LAST && !done_sync) begin
                        sc_data_enb <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
                        wd_cnt      <= '0;
`endif
                        state       <= SHIFT;
                    end else if (arm_cnt != ARM_LAST) begin
                        arm_cnt <= arm_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (done_rise) begin
                        cap_cnt <= 1'b0;
                        state   <= CAPTURE;
`ifdef SCAN_TIMEOUT_EN
                    end else if (wd_cnt == WD_LAST) begin
                        rdata <= '0;
                        err   <= 1'b1;
                        ack   <= 1'b1;
                        state <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                CAPTURE: begin
                    if (cap_cnt) begin
                        rdata <= sc_out;
`ifdef SCAN_TIMEOUT_EN
                        err   <= 1'b0;
`endif
                        ack   <= 1'b1;
                        state <= RESP;
                    end else begin
                        cap_cnt <= 1'b1;
                    end
                end
                RESP: begin
                    sc_clk_enb  <= 1'b1;
                    sc_data_enb <= 1'b1;
                    grant       <= 2'b00;
                    busy        <= 1'b0;
                    rr_last     <= cur_idx;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Directed bench for scan_chain_sequencer with a behavioural datapath that
// returns the previously scanned word. Build with SCAN_TIMEOUT_EN defined to
// also exercise the watchdog.
module tb_scan_chain_sequencer;

    localparam int DATA_W         = 12;
    localparam int SC_DIV         = 4;
    localparam int ARM_CYCLES     = 8;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int SHIFT_CYCLES   = (DATA_W + 1) * SC_DIV;
    localparam int GRANT_TO_ACK   = ARM_CYCLES + SHIFT_CYCLES + 2 + 3;
    localparam int STALE_HOLD     = 30;

    logic              clki = 1'b0;
    logic              rst_n;
    logic [1:0]        req;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        grant;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic              sc_clk_enb;
    logic              sc_data_enb;
    logic [DATA_W-1:0] sc_data_in;
    logic [DATA_W-1:0] sc_out;
    logic              sc_done;

    logic [DATA_W-1:0] prev_word;
    logic [DATA_W-1:0] rx_word;
    logic              done_reg;
    logic              stale_done;
    logic              never_done;
    int                shift_cnt;

    int vectors     = 0;
    int miscompares = 0;

    scan_chain_sequencer #(
        .DATA_W         (DATA_W),
        .SC_DIV         (SC_DIV),
        .ARM_CYCLES     (ARM_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clki        (clki),
        .rst_n       (rst_n),
        .req         (req),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .grant       (grant),
        .ack         (ack),
        .rdata       (rdata),
        .err         (err),
        .busy        (busy),
        .sc_clk_enb  (sc_clk_enb),
        .sc_data_enb (sc_data_enb),
        .sc_data_in  (sc_data_in),
        .sc_out      (sc_out),
        .sc_done     (sc_done)
    );

    always #5 clki = ~clki;

    // Datapath model: a scan takes SHIFT_CYCLES while both enables are low,
    // then shifts out the previous word and raises done.
    assign sc_done = done_reg | stale_done;

    initial begin
        prev_word = '0;
        rx_word   = '0;
        sc_out    = '0;
        done_reg  = 1'b0;
        shift_cnt = 0;
    end

    always @(posedge clki) begin
        if (sc_data_enb || sc_clk_enb) begin
            shift_cnt <= 0;
            done_reg  <= 1'b0;
        end else if (!done_reg && !never_done) begin
            if (shift_cnt == SHIFT_CYCLES - 1) begin
                done_reg  <= 1'b1;
                sc_out    <= prev_word;
                prev_word <= sc_data_in;
                rx_word   <= sc_data_in;
            end
            shift_cnt <= shift_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1);
        @(negedge clki);
        req    = r;
        wdata0 = w0;
        wdata1 = w1;
    endtask

    task automatic waitGrant(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (grant !== 2'b00) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic waitAck(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (ack === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Hard stop in case something leaves the bench stuck.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        logic [1:0]        exp_grant [3];
        logic [DATA_W-1:0] exp_rx    [3];
        logic [DATA_W-1:0] exp_rdata [3];
        int  n;
        int  lat;
        logic seen_ack;

        exp_grant = '{2'b01, 2'b10, 2'b01};
        exp_rx    = '{12'h123, 12'h456, 12'h123};
        exp_rdata = '{12'hA5C, 12'h123, 12'h456};

        rst_n      = 1'b0;
        req        = 2'b00;
        wdata0     = '0;
        wdata1     = '0;
        stale_done = 1'b0;
        never_done = 1'b0;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_ack", 32'(ack), 32'h0);
        checkOutput("rst_rdata", 32'(rdata), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_clk_enb", 32'(sc_clk_enb), 32'h1);
        checkOutput("rst_data_enb", 32'(sc_data_enb), 32'h1);
        checkOutput("rst_data_in", 32'(sc_data_in), 32'h0);
        @(negedge clki);
        rst_n = 1'b1;
        tick();

        $display("[TB] single request");
        applyStimulus(2'b01, 12'hA5C, 12'h000);
        waitGrant(10, n);
        checkOutput("single_req_to_grant", 32'(n), 32'd1);
        checkOutput("single_grant", 32'(grant), 32'h1);
        checkOutput("single_busy", 32'(busy), 32'h1);
        checkOutput("single_arm_clk_enb", 32'(sc_clk_enb), 32'h0);
        checkOutput("single_arm_data_enb", 32'(sc_data_enb), 32'h1);
        checkOutput("single_data_in", 32'(sc_data_in), 32'hA5C);
        waitAck(300, lat);
        req = 2'b00;
        checkOutput("single_latency", 32'(lat), 32'(GRANT_TO_ACK));
        checkOutput("single_model_rx", 32'(rx_word), 32'hA5C);
        checkOutput("single_rdata", 32'(rdata), 32'h000);
        checkOutput("single_err", 32'(err), 32'h0);
        checkOutput("single_grant_at_ack", 32'(grant), 32'h1);
        tick();
        checkOutput("single_ack_pulse", 32'(ack), 32'h0);
        checkOutput("single_grant_cleared", 32'(grant), 32'h0);
        checkOutput("single_busy_cleared", 32'(busy), 32'h0);
        checkOutput("single_clk_enb_idle", 32'(sc_clk_enb), 32'h1);
        checkOutput("single_data_enb_idle", 32'(sc_data_enb), 32'h1);

        $display("[TB] simultaneous requests");
        @(negedge clki);
        rst_n = 1'b0;
        tick();
        @(negedge clki);
        rst_n = 1'b1;
        applyStimulus(2'b11, 12'h123, 12'h456);
        for (int i = 0; i < 3; i++) begin
            waitGrant(10, n);
            checkOutput($sformatf("rr%0d_grant_delay", i), 32'(n), (i == 0) ? 32'd1 : 32'd2);
            checkOutput($sformatf("rr%0d_grant", i), 32'(grant), 32'(exp_grant[i]));
            waitAck(300, lat);
            if (i == 2) begin
                req        = 2'b00;
                stale_done = 1'b1;
            end
            checkOutput($sformatf("rr%0d_latency", i), 32'(lat), 32'(GRANT_TO_ACK));
            checkOutput($sformatf("rr%0d_model_rx", i), 32'(rx_word), 32'(exp_rx[i]));
            checkOutput($sformatf("rr%0d_rdata", i), 32'(rdata), 32'(exp_rdata[i]));
        end

        $display("[TB] stale done");
        repeat (3) tick();
        applyStimulus(2'b10, 12'h000, 12'h3C3);
        waitGrant(10, n);
        checkOutput("stale_grant", 32'(grant), 32'h2);
        repeat (STALE_HOLD) tick();
        checkOutput("stale_still_arm", 32'(sc_data_enb), 32'h1);
        @(negedge clki);
        stale_done = 1'b0;
        waitAck(300, lat);
        req = 2'b00;
        checkOutput("stale_latency", 32'(STALE_HOLD + lat), 32'(STALE_HOLD + 3 + GRANT_TO_ACK - ARM_CYCLES));
        checkOutput("stale_model_rx", 32'(rx_word), 32'h3C3);
        checkOutput("stale_rdata", 32'(rdata), 32'h123);

        $display("[TB] reset mid-shift");
        repeat (3) tick();
        applyStimulus(2'b01, 12'h777, 12'h000);
        waitGrant(10, n);
        repeat (20) tick();
        checkOutput("midrst_in_shift", 32'(sc_data_enb), 32'h0);
        @(negedge clki);
        rst_n = 1'b0;
        req   = 2'b00;
        tick();
        checkOutput("midrst_clk_enb", 32'(sc_clk_enb), 32'h1);
        checkOutput("midrst_data_enb", 32'(sc_data_enb), 32'h1);
        checkOutput("midrst_grant", 32'(grant), 32'h0);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        @(negedge clki);
        rst_n = 1'b1;
        seen_ack = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (ack === 1'b1) seen_ack = 1'b1;
        end
        checkOutput("midrst_no_ack", 32'(seen_ack), 32'h0);

        $display("[TB] wdata change after grant");
        applyStimulus(2'b01, 12'h111, 12'h000);
        waitGrant(10, n);
        checkOutput("wchg_req_to_grant", 32'(n), 32'd1);
        repeat (3) tick();
        @(negedge clki);
        wdata0 = 12'h222;
        waitAck(300, lat);
        req = 2'b00;
        checkOutput("wchg_latency", 32'(3 + lat), 32'(GRANT_TO_ACK));
        checkOutput("wchg_model_rx", 32'(rx_word), 32'h111);
        checkOutput("wchg_rdata", 32'(rdata), 32'h3C3);
        checkOutput("wchg_err", 32'(err), 32'h0);

`ifdef SCAN_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        repeat (3) tick();
        never_done = 1'b1;
        applyStimulus(2'b01, 12'h555, 12'h000);
        waitGrant(10, n);
        waitAck(400, lat);
        req = 2'b00;
        checkOutput("timeout_latency", 32'(lat), 32'(ARM_CYCLES + TIMEOUT_CYCLES));
        checkOutput("timeout_err", 32'(err), 32'h1);
        checkOutput("timeout_rdata", 32'(rdata), 32'h0);
        tick();
        never_done = 1'b0;
        checkOutput("timeout_grant_cleared", 32'(grant), 32'h0);
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scan_chain_sequencer.md
# scan_chain_sequencer

Controller that owns the chip scan-chain datapath and shares it between two requesters, the okHost command path and an on-FPGA calibration loop. It arbitrates round-robin, loads the winner's word into the datapath, and drives the datapath's clock-enable and data-enable. It waits for the datapath's done flag, captures the scanned-out word and returns it to the winning requester with a one-cycle acknowledge.

## Interface
Parameters:
- DATA_W, 12: scan word width; must equal the datapath code length.
- SC_DIV, 2000000: datapath scan-clock divide ratio, in clki cycles per scan-clock period.
- ARM_CYCLES, SC_DIV+4: minimum clki cycles data-enable is held asserted, guaranteeing at least one scan-clock negedge.
- TIMEOUT_CYCLES, 64*SC_DIV: SHIFT-state watchdog limit; used only when the timeout macro is defined.

Ports:
- clki, input, 1: system clock, 100 MHz.
- rst_n, input, 1: reset, synchronous, active-low.
- req, input, 2: request level per requester; bit0 = host, bit1 = calibration.
- wdata0, input, DATA_W: word to scan in for requester 0.
- wdata1, input, DATA_W: word to scan in for requester 1.
- grant, output, 2: one-hot; high for the whole transaction of the served requester.
- ack, output, 1: one-cycle pulse that ends a transaction.
- rdata, output, DATA_W: scanned-out word; valid from the ack cycle and held until the next ack.
- err, output, 1: timeout flag; valid with ack.
- busy, output, 1: high in every state except IDLE.
- sc_clk_enb, output, 1: to datapath; 1 stops and clears the scan clock.
- sc_data_enb, output, 1: to datapath; 1 resets the bit counter and the done flag.
- sc_data_in, output, DATA_W: word presented to the datapath.
- sc_out, input, DATA_W: datapath readback word.
- sc_done, input, 1: datapath done flag; asynchronous to clki and double-flopped internally.

## Operation
- Reset values: grant=0, ack=0, rdata=0, err=0, busy=0, sc_clk_enb=1, sc_data_enb=1, sc_data_in=0, state=IDLE, rr_last=1 (so requester 0 wins first).
- **IDLE**:
  - If any req bit is high, pick the winner round-robin: the requester not served last wins if both request.
  - Latch the winner's wdata into sc_data_in, set grant, go to ARM.
- **ARM**:
  - sc_clk_enb=0 and sc_data_enb=1.
  - Count ARM_CYCLES.
  - Leave only when the count has expired AND synchronized done is 0; then go to SHIFT.
- **SHIFT**:
  - sc_data_enb=0.
  - Wait for a rising edge of synchronized done, then go to CAPTURE.
- **CAPTURE**:
  - Wait 2 clki cycles so sc_out settles under the synchronizer.
  - Register sc_out into rdata, go to RESP.
- **RESP**:
  - ack=1 for one cycle.
  - Set sc_clk_enb=1 and sc_data_enb=1, clear grant, update rr_last, go to IDLE.
- A requester holds req high until it sees ack. A req that drops mid-transaction is ignored and the transaction completes. A req still high after ack is treated as a new request.
- Simultaneous requests: round-robin strictly alternates between requesters.
- wdata is sampled only on the IDLE→ARM transition; later changes are ignored.
- Synchronous reset in any state: all outputs return to their reset values the next cycle and the in-flight transaction is dropped without ack.

## Timing
- Request to grant: 1 clki cycle.
- Grant to ack: ARM_CYCLES + shift time + synchronizer delay + 3 cycles.
  - Shift time is (DATA_W+1) scan-clock periods; one scan-clock period is SC_DIV clki cycles.
  - Synchronizer delay is 2 cycles.
- ack to next grant: minimum 1 IDLE cycle.
- Counter widths are $clog2 of the largest count. Counters saturate; they never wrap.

## Configuration
- SCAN_TIMEOUT_EN defined:
  - A watchdog counts clki cycles in SHIFT.
  - At TIMEOUT_CYCLES it forces RESP with err=1 and rdata=0.
- Undefined: no watchdog, err is tied to 0, and SHIFT waits indefinitely.

## Structure
- Shared package scan_pkg holds:
  - the state enum (IDLE, ARM, SHIFT, CAPTURE, RESP);
  - DATA_W default;
  - SC_DIV default.
- One sub-module, sc_sync2: 2-flop synchronizer plus rising-edge detect for sc_done.
- The round-robin arbiter is inline.

## Test plan
The bench uses SC_DIV=4, ARM_CYCLES=8, TIMEOUT_CYCLES=200, and a behavioural datapath model that echoes the previous word.
- Single request: req=01, wdata0=12'hA5C → grant=01 next cycle; ack after the computed latency; model sees 12'hA5C; err=0.
- Simultaneous requests: req=11 held → grants in order 01, 10, 01; each ack carries the correct echo.
- Stale done: model leaves done=1 from the previous scan → controller holds ARM until done drops; no early CAPTURE.
- Timeout with SCAN_TIMEOUT_EN: model never raises done → ack at SHIFT entry + 200 cycles, err=1, rdata=0.
- Reset mid-SHIFT: rst_n=0 for 1 cycle → next cycle sc_clk_enb=1, sc_data_enb=1, grant=0, no ack; a new req is then served normally.
- wdata changed after grant: wdata0 switches 12'h111→12'h222 during ARM → model receives 12'h111.
